// File: rtl/t_codec_pkg.sv
// Shared types and constants for the toggle-line decoder.
// Holds the FSM state enum, queue depth and default word width.
package t_codec_pkg;

    typedef enum logic {
        SEED = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int QUEUE_DEPTH    = 2;
    localparam int WORD_W_DEFAULT = 8;

endpackage

// File: rtl/t_word_queue.sv
// Two-entry FIFO holding completed words.
// Ports: clk, rst (sync high), push/push_data in, pop in
// (ignored when empty), head out, full/empty flags out.
module t_word_queue
    import t_codec_pkg::*;
#(
    parameter int W = WORD_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem0_q, mem0_d;
    logic [W-1:0] mem1_q, mem1_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;
    logic         do_push;

    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'(QUEUE_DEPTH));
    assign head  = mem0_q;

    // A push into a full queue only lands if a pop frees a slot
    // in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem0_d  = mem0_q;
        mem1_d  = mem1_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (do_push) begin
                    mem0_d  = push_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (do_pop && do_push) begin
                    mem0_d = push_data;
                end else if (do_pop) begin
                    count_d = 2'd0;
                end else if (do_push) begin
                    mem1_d  = push_data;
                    count_d = 2'd2;
                end
            end
            default: begin
                if (do_pop) begin
                    mem0_d = mem1_q;
                    if (do_push) begin
                        mem1_d = push_data;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem0_q  <= '0;
            mem1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            mem0_q  <= mem0_d;
            mem1_q  <= mem1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/t_toggle_decoder.sv
// Recovers T bits from a toggle-encoded line (T = Q ^ Q_prev) and
// packs them LSB-first into words delivered over valid/ready.
// Ports: Clock, Reset (sync high), SampleEn/Q/Resync line side;
// T/TValid bit out; WordData/WordValid/WordReady word port;
// BitCount partial-word fill; Overflow sticky drop flag, ClearOvf.
module t_toggle_decoder
    import t_codec_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT,
    parameter int CNT_W  = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              SampleEn,
    input  logic              Q,
    input  logic              Resync,
    output logic              T,
    output logic              TValid,
    output logic [WORD_W-1:0] WordData,
    output logic              WordValid,
    input  logic              WordReady,
    output logic [CNT_W-1:0]  BitCount,
    output logic              Overflow,
    input  logic              ClearOvf
);

    state_e            state_q, state_d;
    logic              q_ref_q, q_ref_d;
    logic [WORD_W-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              t_q, t_d;
    logic              tvalid_q, tvalid_d;
    logic              ovf_q, ovf_d;

    logic              t_bit;
    logic              word_last;
    logic              push;
    logic              drop;
    logic              q_full;
    logic              q_empty;
    logic [WORD_W-1:0] push_data;

    assign t_bit     = Q ^ q_ref_q;
    assign word_last = (cnt_q == CNT_W'(WORD_W - 1));
    // The final bit goes straight into the pushed word, so the
    // shift register only ever holds WORD_W-1 bits.
    assign push_data = {t_bit, shift_q};

    always_comb begin
        state_d  = state_q;
        q_ref_d  = q_ref_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        t_d      = t_q;
        tvalid_d = 1'b0;
        push     = 1'b0;
        if (Resync) begin
            state_d = SEED;
            shift_d = '0;
            cnt_d   = '0;
        end else if (SampleEn) begin
            q_ref_d = Q;
            if (state_q == SEED) begin
                state_d = RUN;
            end else begin
                t_d      = t_bit;
                tvalid_d = 1'b1;
                if (word_last) begin
                    push    = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                end else begin
                    shift_d[cnt_q] = t_bit;
                    cnt_d          = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // A drop sets the flag even when ClearOvf is asserted alongside.
    assign drop  = push && q_full && !WordReady;
    assign ovf_d = drop | (ovf_q & ~ClearOvf);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= SEED;
            q_ref_q  <= 1'b0;
            shift_q  <= '0;
            cnt_q    <= '0;
            t_q      <= 1'b0;
            tvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_ref_q  <= q_ref_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            t_q      <= t_d;
            tvalid_q <= tvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    t_word_queue #(
        .W(WORD_W)
    ) u_queue (
        .clk       (Clock),
        .rst       (Reset),
        .push      (push),
        .push_data (push_data),
        .pop       (WordReady),
        .head      (WordData),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign WordValid = !q_empty;
    assign T         = t_q;
    assign TValid    = tvalid_q;
    assign BitCount  = cnt_q;
    assign Overflow  = ovf_q;

endmodule
